mont_cond_sub: RTL and testbench

//  Multi-cycle conditional final subtractor for the Montgomery datapath: given an

---
 rtl/rsa_pkg.sv | 12 +
 rtl/sub_chunk.sv | 17 +
 rtl/mont_cond_sub.sv | 135 +++++++++++++
 tb/tb_mont_cond_sub.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared widths and FSM encoding for the RSA/Montgomery datapath blocks.
package rsa_pkg;
  localparam int RSA_KEY_W   = 256;
  localparam int RSA_ACC_W   = 258;
  localparam int SUB_CHUNK_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;
endpackage

// File: rtl/sub_chunk.sv
// One CHUNK-wide slice of a - b - bin, built as a + ~b + ~bin so the adder
// carry-out is the inverted borrow-out.
module sub_chunk #(
  parameter int CHUNK = 64
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_bin,
  output logic [CHUNK-1:0] o_d,
  output logic             o_bout
);
  logic [CHUNK:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {{CHUNK{1'b0}}, ~i_bin};
  assign o_d    = w_sum[CHUNK-1:0];
  assign o_bout = ~w_sum[CHUNK];
endmodule

// File: rtl/mont_cond_sub.sv
// Multi-cycle conditional final subtractor: R = (S >= N) ? S - N : S,
// one CHUNK per cycle LSB-first through a registered borrow.
module mont_cond_sub
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_ACC_W,
  parameter int CHUNK = SUB_CHUNK_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     s_in,
  input  logic [RSA_KEY_W-1:0] n_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     r_out,
  output logic                 reduced
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  sub_state_e           r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_reduced;
  logic                 r_borrow;
  logic [IDXW-1:0]      r_idx;
  logic [WIDTH-1:0]     r_s;
  logic [WIDTH-1:0]     r_d;
  logic [WIDTH-1:0]     r_res;
  logic [RSA_KEY_W-1:0] r_n;

  logic [PADW-1:0]      w_s_pad;
  logic [PADW-1:0]      w_n_pad;
  logic [PADW-1:0]      w_d_pad;
  logic [CHUNK-1:0]     w_a;
  logic [CHUNK-1:0]     w_b;
  logic [CHUNK-1:0]     w_diff;
  logic                 w_bout;

  // Zero padding above WIDTH makes the top-chunk borrow equal the bit-WIDTH borrow.
  assign w_s_pad = PADW'(r_s);
  assign w_n_pad = PADW'(r_n);

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_idx == IDXW'(c)) begin
        w_a = w_s_pad[c*CHUNK +: CHUNK];
        w_b = w_n_pad[c*CHUNK +: CHUNK];
      end
    end
  end

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_bin (r_borrow),
    .o_d   (w_diff),
    .o_bout(w_bout)
  );

  always_comb begin
    w_d_pad = PADW'(r_d);
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_idx == IDXW'(c)) w_d_pad[c*CHUNK +: CHUNK] = w_diff;
    end
  end

  if (PADW > WIDTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = |w_d_pad[PADW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_reduced   <= 1'b0;
      r_borrow    <= 1'b0;
      r_idx       <= '0;
      r_s         <= '0;
      r_n         <= '0;
      r_d         <= '0;
      r_res       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s        <= s_in;
            r_n        <= n_in;
            r_borrow   <= 1'b0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_SUB;
          end
        end
        ST_SUB: begin
          r_d      <= w_d_pad[WIDTH-1:0];
          r_borrow <= w_bout;
          if (r_idx == LAST_IDX) begin
            // Final borrow set means S < N: pass S through untouched.
            r_res       <= w_bout ? r_s : w_d_pad[WIDTH-1:0];
            r_reduced   <= ~w_bout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign r_out     = r_res;
  assign reduced   = r_reduced;
endmodule

// File: tb/tb_mont_cond_sub.sv
// Bench for mont_cond_sub: behavioural reference with expected queue, directed
// corner cases and randomized back-to-back traffic.
module tb_mont_cond_sub;
  import rsa_pkg::*;

  localparam int W      = RSA_ACC_W;
  localparam int WX     = RSA_ACC_W + 1;
  localparam int KW     = RSA_KEY_W;
  localparam int LAT    = 5;
  localparam int PERIOD = 7;
  localparam int NRAND  = 2000;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds data stable until that edge.

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  s_in = '0;
  logic [KW-1:0] n_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  r_out;
  logic          reduced;

  mont_cond_sub dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_in     (s_in),
    .n_in     (n_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r_out    (r_out),
    .reduced  (reduced)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W:0] exp_q[$];
  bit         chk_en    = 1'b0;
  bit         tput_mode = 1'b0;
  bit         m_idle    = 1'b1;
  bit         valid_before;
  bit         exp_valid;
  int         e        = 0;
  int         m_acc    = 0;
  int         last_acc = -1;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns {reduced, R}.
  function automatic logic [W:0] ref_model(input logic [W-1:0] s, input logic [KW-1:0] n);
    logic [WX-1:0] sx;
    logic [WX-1:0] nx;
    sx = WX'(s);
    nx = WX'(n);
    if (sx >= nx) return {1'b1, W'(sx - nx)};
    return {1'b0, s};
  endfunction

  // Model of the handshake timeline, updated from the inputs at each edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_idle   = 1'b1;
      last_acc = -1;
    end else begin
      e++;
      valid_before = !m_idle && ((e - 1 - m_acc) >= LAT);
      if (m_idle && in_valid) begin
        exp_q.push_back(ref_model(s_in, n_in));
        m_idle = 1'b0;
        if (tput_mode && last_acc >= 0) chk("throughput", e - last_acc, PERIOD);
        last_acc = e;
        m_acc    = e;
      end else if (valid_before && out_ready) begin
        m_idle = 1'b1;
        void'(exp_q.pop_front());
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      exp_valid = !m_idle && ((e - m_acc) >= LAT);
      chk("in_ready", in_ready, m_idle);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid && exp_q.size() > 0) begin
        chk("r_out", r_out, exp_q[0][W-1:0]);
        chk("reduced", reduced, exp_q[0][W]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [KW-1:0] rand_n();
    logic [KW-1:0] v;
    for (int j = 0; j < KW / 32; j++) v[j*32 +: 32] = $urandom();
    if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(1, 250);
    if (v == '0) v = KW'(1);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_s(input logic [KW-1:0] n);
    logic [287:0]  big;
    logic [WX-1:0] twon;
    int            pick;
    for (int j = 0; j < 9; j++) big[j*32 +: 32] = $urandom();
    twon = WX'(n) << 1;
    pick = $urandom_range(0, 9);
    if (pick == 0) return W'(WX'(n));
    if (pick == 1) return W'(twon - WX'(1));
    if (pick == 2) return W'(WX'(n) - WX'(1));
    return W'(WX'(big) % twon);
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] s, input logic [KW-1:0] n,
                        input logic [W-1:0] exp_r, input logic exp_red, input int stall);
    int lat;
    @(posedge clk); #1;
    s_in      = s;
    n_in      = n;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    s_in     = {$urandom(), $urandom(), $urandom()};
    n_in     = {$urandom(), $urandom()};
    lat = 0;
    while (!out_valid && lat < 30) begin
      in_valid = (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_r"}, r_out, exp_r);
    chk({tag, "_reduced"}, reduced, exp_red);
    for (int i = 0; i < stall; i++) begin
      in_valid = (i == 3);
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, out_valid, 1'b1);
      chk({tag, "_stall_r"}, r_out, exp_r);
      chk({tag, "_stall_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_post_valid"}, out_valid, 1'b0);
    chk({tag, "_post_in_ready"}, in_ready, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [KW-1:0] n;
    logic [W-1:0]  s;
    int            to;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_r_out", r_out, '0);
    chk("rst_reduced", reduced, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // S == N, all ones: borrow ripples through and lands on zero.
    n = '1;
    run_op("eq_ones", W'(n), n, '0, 1'b1, 0);

    // S = N - 1 with N = 2^255 + 1.
    n = (KW'(1) << 255) + KW'(1);
    run_op("below_n", W'(1) << 255, n, W'(1) << 255, 1'b0, 0);

    // S = 2N - 1 with N = 2^255 + 3: S = 2^256 + 5, R = 2^255 + 2. Stall in DONE.
    n = (KW'(1) << 255) + KW'(3);
    run_op("two_n_m1", (W'(1) << 256) + W'(5), n, (W'(1) << 255) + W'(2), 1'b1, 10);

    // Reset during the third SUB cycle.
    @(posedge clk); #1;
    s_in = W'(12345); n_in = KW'(678); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_r_out", r_out, '0);
    rst_n = 1'b1;
    run_op("after_abort", W'(5), KW'(3), W'(2), 1'b1, 0);

    // Random back-to-back traffic.
    last_acc  = -1;
    tput_mode = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NRAND; i++) begin
      n        = rand_n();
      s        = rand_s(n);
      s_in     = s;
      n_in     = n;
      in_valid = 1'b1;
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!in_ready && to < 50);
      if (!in_ready) begin
        chk("accept_timeout", in_ready, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    tput_mode = 1'b0;
    to = 0;
    while (!m_idle && to < 50) begin
      @(posedge clk);
      to++;
    end
    chk("drain_timeout", m_idle, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
